// File: rtl/led_export_pkg.sv
// Shared types and sizing helpers for the LED frame exporter.
package led_export_pkg;

    typedef enum logic [2:0] {
        ST_IDLE  = 3'd0,
        ST_START = 3'd1,
        ST_DATA  = 3'd2,
        ST_SEP   = 3'd3,
        ST_END   = 3'd4
    } state_e;

    function automatic int clog2_f(input int v);
        int r;
        r = 0;
        for (int i = 0; i < 31; i++) begin
            if ((32'sd1 <<< i) < v) begin
                r = i + 1;
            end
        end
        return r;
    endfunction

    // Width of an index/select field that must be at least one bit wide.
    function automatic int width_min1_f(input int n);
        return (n <= 1) ? 1 : clog2_f(n);
    endfunction

    function automatic int nchunk_f(input int data_w, input int chunk_w);
        return (data_w + chunk_w - 1) / chunk_w;
    endfunction

endpackage

// File: rtl/phase_timer.sv
// Per-phase hold counter: counts 0..HOLD-1 and flags the final cycle of a phase.
module phase_timer
    import led_export_pkg::*;
#(
    parameter int HOLD = 5
) (
    input  logic clk,
    input  logic rst,
    input  logic clr,
    input  logic en,
    output logic last
);

    localparam int CNT_W = width_min1_f(HOLD);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(HOLD - 1);

    logic [CNT_W-1:0] cnt_q;

    assign last = (cnt_q == CNT_LAST);

    // Phase counter, wrapping on the last cycle so back-to-back phases need no gap.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cnt_q <= {CNT_W{1'b0}};
        end else if (clr) begin
            cnt_q <= {CNT_W{1'b0}};
        end else if (en) begin
            if (last) begin
                cnt_q <= {CNT_W{1'b0}};
            end else begin
                cnt_q <= cnt_q + {{(CNT_W-1){1'b0}}, 1'b1};
            end
        end else begin
            cnt_q <= cnt_q;
        end
    end

endmodule

// File: rtl/led_frame_exporter.sv
// Serialises a selected channel word onto an LED bank as START, chunk/SEP..., END frames.
module led_frame_exporter
    import led_export_pkg::*;
#(
    parameter int NCH    = 4,
    parameter int DATA_W = 32,
    parameter int LED_W  = 8,
    parameter int HOLD   = 5,
    localparam int SEL_W = width_min1_f(NCH)
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic [NCH*DATA_W-1:0] data,
    input  logic [SEL_W-1:0]      ch_sel,
    input  logic                  start,
    input  logic                  rep,
    input  logic                  abort,
    output logic [LED_W-1:0]      leds,
    output logic                  busy,
    output logic                  done
);

    localparam int CHUNK_W = LED_W - 1;
    localparam int NCHUNK  = nchunk_f(DATA_W, CHUNK_W);
    localparam int PAD_W   = NCHUNK * CHUNK_W;
    localparam int IDX_W   = width_min1_f(NCHUNK);
    localparam logic [IDX_W-1:0] IDX_LAST = IDX_W'(NCHUNK - 1);
    localparam logic [LED_W-1:0] MARK_ALL = {LED_W{1'b1}};
    localparam logic [LED_W-1:0] MARK_SEP = {1'b1, {CHUNK_W{1'b0}}};

    state_e             state_q;
    logic [DATA_W-1:0]  word_q;
    logic [SEL_W-1:0]   ch_q;
    logic [IDX_W-1:0]   idx_q;
    logic [LED_W-1:0]   leds_q;
    logic               busy_q;
    logic               done_q;

    logic               last_s;
    logic               tmr_clr_s;
    logic [SEL_W-1:0]   mux_ch_s;
    logic [DATA_W-1:0]  word_in_s;
    logic [IDX_W-1:0]   chunk_idx_s;
    logic [PAD_W-1:0]   word_pad_s;
    logic [CHUNK_W-1:0] chunk_s;

    assign tmr_clr_s = (state_q == ST_IDLE) || abort;

    phase_timer #(.HOLD(HOLD)) u_timer (
        .clk  (clk),
        .rst  (rst),
        .clr  (tmr_clr_s),
        .en   (1'b1),
        .last (last_s)
    );

    // Channel feeding the word latch: live select in IDLE (out-of-range maps to 0), latched one on repeat.
    always_comb begin
        mux_ch_s = ch_q;
        if (state_q == ST_IDLE) begin
            if (int'(ch_sel) < NCH) begin
                mux_ch_s = ch_sel;
            end else begin
                mux_ch_s = {SEL_W{1'b0}};
            end
        end else begin
            mux_ch_s = ch_q;
        end
    end

    assign word_in_s  = data[int'(mux_ch_s)*DATA_W +: DATA_W];
    assign word_pad_s = PAD_W'(word_q);

    // Chunk shown on entry to DATA: first chunk after START, the following one after SEP.
    always_comb begin
        chunk_idx_s = {IDX_W{1'b0}};
        if (state_q == ST_SEP) begin
            chunk_idx_s = idx_q + {{(IDX_W-1){1'b0}}, 1'b1};
        end else begin
            chunk_idx_s = {IDX_W{1'b0}};
        end
    end

    assign chunk_s = word_pad_s[int'(chunk_idx_s)*CHUNK_W +: CHUNK_W];

    // Frame FSM with registered LED, busy and done outputs.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= ST_IDLE;
            word_q  <= {DATA_W{1'b0}};
            ch_q    <= {SEL_W{1'b0}};
            idx_q   <= {IDX_W{1'b0}};
            leds_q  <= {LED_W{1'b0}};
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
        end else begin
            done_q <= 1'b0;
            if (state_q == ST_IDLE) begin
                if (start) begin
                    word_q  <= word_in_s;
                    ch_q    <= mux_ch_s;
                    idx_q   <= {IDX_W{1'b0}};
                    state_q <= ST_START;
                    leds_q  <= MARK_ALL;
                    busy_q  <= 1'b1;
                end else begin
                    leds_q  <= {LED_W{1'b0}};
                    busy_q  <= 1'b0;
                end
            end else if (abort) begin
                state_q <= ST_IDLE;
                leds_q  <= {LED_W{1'b0}};
                busy_q  <= 1'b0;
            end else if (last_s) begin
                case (state_q)
                    ST_START: begin
                        state_q <= ST_DATA;
                        leds_q  <= {1'b0, chunk_s};
                    end
                    ST_DATA: begin
                        if (idx_q == IDX_LAST) begin
                            state_q <= ST_END;
                            leds_q  <= MARK_ALL;
                        end else begin
                            state_q <= ST_SEP;
                            leds_q  <= MARK_SEP;
                        end
                    end
                    ST_SEP: begin
                        idx_q   <= chunk_idx_s;
                        state_q <= ST_DATA;
                        leds_q  <= {1'b0, chunk_s};
                    end
                    ST_END: begin
                        done_q <= 1'b1;
                        if (rep) begin
                            word_q  <= word_in_s;
                            idx_q   <= {IDX_W{1'b0}};
                            state_q <= ST_START;
                            leds_q  <= MARK_ALL;
                        end else begin
                            state_q <= ST_IDLE;
                            leds_q  <= {LED_W{1'b0}};
                            busy_q  <= 1'b0;
                        end
                    end
                    default: begin
                        state_q <= ST_IDLE;
                        leds_q  <= {LED_W{1'b0}};
                        busy_q  <= 1'b0;
                    end
                endcase
            end else begin
                state_q <= state_q;
            end
        end
    end

    assign leds = leds_q;
    assign busy = busy_q;
    assign done = done_q;

endmodule
